issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/sched_pkg.sv | 13 +
 rtl/prio_pick.sv | 19 +
 rtl/issue_sched.sv | 166 ++++++++++++++++
 tb/tb_issue_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and constants for the issue scheduler.
package sched_pkg;

  localparam int unsigned DEFAULT_STARVE_LIMIT = 7;
  localparam int unsigned TAG_W                = 8;
  localparam int unsigned PAYLOAD_W            = 16;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit picker: one-hot grant of the lowest request not in the exclusion mask.
module prio_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] excl,
  output logic [N-1:0] gnt_c,
  output logic         any_c
);

  logic [N-1:0] masked;

  always_comb begin : pick_comb
    masked = req & ~excl;
    gnt_c  = masked & (~masked + N'(1));
    any_c  = |masked;
  end

endmodule

// File: rtl/issue_sched.sv
// Oldest-first multi-port issue scheduler with entry-0 starvation guard.
// Optional ISSUE_SCHED_STATS_EN adds issue_cnt / stall_cnt counters.
module issue_sched
  import sched_pkg::*;
#(
  parameter int unsigned Size        = 4,
  parameter int unsigned Ports       = 2,
  parameter int unsigned StarveLimit = DEFAULT_STARVE_LIMIT,
  parameter type         T           = sched_pkg::entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(Size+1)-1:0] q_size,
  input  T                          q_data    [Size],
  input  logic                      q_rdy     [Size],
  input  logic                      flush,
  input  logic                      out_ready [Ports],
  output logic                      pop       [Size],
  output logic                      out_valid [Ports],
  output T                          out_data  [Ports]
`ifdef ISSUE_SCHED_STATS_EN
  ,
  output logic [31:0]               issue_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int unsigned SW = $clog2(Size+1);
  localparam int unsigned CW = $clog2(StarveLimit+1);

  logic [Size-1:0]  live;
  logic [Size-1:0]  cand;
  logic [Ports-1:0] port_free;
  logic [Ports-1:0] load;
  logic [Size-1:0]  sel [Ports];
  logic             starved;
  logic             sel0;
  logic             younger;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [Ports-1:0] out_valid_q, out_valid_d;
  T                 out_data_q [Ports];
  T                 out_data_d [Ports];

  assign starved = (cnt_q == CW'(StarveLimit));

  // Once entry 0 has starved, it is the only eligible candidate.
  always_comb begin : cand_comb
    live = '0;
    cand = '0;
    for (int i = 0; i < Size; i++) begin
      live[i] = (SW'(i) < q_size);
      cand[i] = live[i] && q_rdy[i] && (!starved || i == 0);
    end
  end

  always_comb begin : free_comb
    port_free = '0;
    for (int p = 0; p < Ports; p++) begin
      port_free[p] = !out_valid_q[p] || out_ready[p];
    end
  end

  // Each port excludes whatever the lower ports already took this cycle.
  for (genvar p = 0; p < Ports; p++) begin : g_port
    logic [Size-1:0] excl;
    logic [Size-1:0] gnt;
    logic [Size-1:0] taken;
    logic            hit;
    logic            fire;

    if (p == 0) begin : g_head
      assign excl = '0;
    end else begin : g_tail
      assign excl = g_port[p-1].excl | g_port[p-1].taken;
    end

    prio_pick #(.N(Size)) u_pick (
      .req   (cand),
      .excl  (excl),
      .gnt_c (gnt),
      .any_c (hit)
    );

    assign fire    = !flush && port_free[p] && hit;
    assign taken   = fire ? gnt : '0;
    assign sel[p]  = taken;
    assign load[p] = fire;

    assign out_valid[p] = out_valid_q[p];
    assign out_data[p]  = out_data_q[p];
  end

  always_comb begin : pop_comb
    for (int i = 0; i < Size; i++) begin
      pop[i] = 1'b0;
      if (!rst) begin
        if (flush) begin
          pop[i] = live[i];
        end else begin
          for (int p = 0; p < Ports; p++) begin
            pop[i] = pop[i] | sel[p][i];
          end
        end
      end
    end
  end

  always_comb begin : next_comb
    sel0        = 1'b0;
    younger     = 1'b0;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    for (int p = 0; p < Ports; p++) begin
      sel0          = sel0 | sel[p][0];
      younger       = younger | (|sel[p][Size-1:1]);
      out_data_d[p] = out_data_q[p];
      for (int i = 0; i < Size; i++) begin
        if (sel[p][i]) out_data_d[p] = q_data[i];
      end
      if (flush)             out_valid_d[p] = 1'b0;
      else if (port_free[p]) out_valid_d[p] = load[p];
    end
    if (flush || q_size == '0 || sel0) cnt_d = '0;
    else if (younger && !starved)      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin : state_ff
    if (rst) begin
      cnt_q       <= '0;
      out_valid_q <= '0;
      for (int p = 0; p < Ports; p++) out_data_q[p] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      for (int p = 0; p < Ports; p++) out_data_q[p] <= out_data_d[p];
    end
  end

`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin : stats_comb
    issue_cnt_d = issue_cnt_q;
    for (int p = 0; p < Ports; p++) begin
      issue_cnt_d = issue_cnt_d + 32'(load[p]);
    end
    stall_cnt_d = stall_cnt_q + 32'((q_size != '0) && (load == '0));
  end

  always_ff @(posedge clk or posedge rst) begin : stats_ff
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_sched.sv
// Directed table-driven bench for issue_sched (Size=4, Ports=2, StarveLimit=7).
module tb_issue_sched;
  import sched_pkg::*;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned PORTS = 2;
  localparam int          NONE  = -1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] q_size;
  entry_t     q_data    [SIZE];
  logic       q_rdy     [SIZE];
  logic       flush;
  logic       out_ready [PORTS];
  logic       pop       [SIZE];
  logic       out_valid [PORTS];
  entry_t     out_data  [PORTS];
`ifdef ISSUE_SCHED_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  issue_sched #(
    .Size(SIZE), .Ports(PORTS), .StarveLimit(7), .T(entry_t)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q_size    (q_size),
    .q_data    (q_data),
    .q_rdy     (q_rdy),
    .flush     (flush),
    .out_ready (out_ready),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef ISSUE_SCHED_STATS_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic entry_t ent(input int idx);
    entry_t e;
    e = '0;
    if (idx >= 0) begin
      e.tag     = 8'(8'hA0 + idx);
      e.payload = 16'(16'h0111 * (idx + 1));
    end
    return e;
  endfunction

  task automatic set_in(input logic [2:0] sz, input logic [3:0] rdy,
                        input logic fl, input logic [1:0] rd);
    q_size = sz;
    flush  = fl;
    for (int i = 0; i < SIZE; i++) q_rdy[i] = rdy[i];
    for (int p = 0; p < PORTS; p++) out_ready[p] = rd[p];
  endtask

  task automatic check_pop(input string name, input logic [3:0] exp);
    logic [3:0] act;
    for (int i = 0; i < SIZE; i++) act[i] = pop[i];
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s pop actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [1:0] ev,
                           input int d0, input int d1);
    logic [1:0] act;
    for (int p = 0; p < PORTS; p++) act[p] = out_valid[p];
    checks++;
    if (act !== ev) begin
      failures++;
      $display("FAIL %s out_valid actual=%b required=%b", name, act, ev);
    end
    checks++;
    if (out_data[0] !== ent(d0)) begin
      failures++;
      $display("FAIL %s out_data0 actual=%h required=%h", name, out_data[0], ent(d0));
    end
    checks++;
    if (out_data[1] !== ent(d1)) begin
      failures++;
      $display("FAIL %s out_data1 actual=%h required=%h", name, out_data[1], ent(d1));
    end
  endtask

  // One cycle: drive at negedge, check pop, then check registered outputs after the edge.
  task automatic step(input string name, input logic [2:0] sz, input logic [3:0] rdy,
                      input logic fl, input logic [1:0] rd, input logic [3:0] exp_pop,
                      input logic [1:0] ev, input int d0, input int d1);
    @(negedge clk);
    set_in(sz, rdy, fl, rd);
    #1 check_pop(name, exp_pop);
    @(posedge clk);
    #1 check_out(name, ev, d0, d1);
  endtask

  typedef struct {
    logic [2:0] sz;
    logic [3:0] rdy;
    logic       fl;
    logic [1:0] rd;
    logic [3:0] pop;
    logic [1:0] ev;
    int         d0;
    int         d1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    // Bit i of rdy/pop is entry i; bit p of rd/ev is port p.
    tbl[0] = '{3'd4, 4'b1111, 1'b0, 2'b11, 4'b0011, 2'b11, 0, 1};
    tbl[1] = '{3'd4, 4'b1010, 1'b0, 2'b11, 4'b1010, 2'b11, 1, 3};
    tbl[2] = '{3'd4, 4'b1111, 1'b0, 2'b10, 4'b0001, 2'b11, 1, 0};
    tbl[3] = '{3'd4, 4'b1111, 1'b0, 2'b00, 4'b0000, 2'b11, 1, 0};
    tbl[4] = '{3'd0, 4'b1111, 1'b0, 2'b11, 4'b0000, 2'b00, 1, 0};
    tbl[5] = '{3'd2, 4'b1111, 1'b0, 2'b11, 4'b0011, 2'b11, 0, 1};
    tbl[6] = '{3'd3, 4'b0100, 1'b0, 2'b01, 4'b0100, 2'b11, 2, 1};
    tbl[7] = '{3'd3, 4'b1111, 1'b1, 2'b00, 4'b0111, 2'b00, 2, 1};
    tbl[8] = '{3'd1, 4'b0001, 1'b0, 2'b11, 4'b0001, 2'b01, 0, 1};

    for (int i = 0; i < SIZE; i++) q_data[i] = ent(i);

    // Reset holds everything low regardless of inputs.
    rst = 1'b1;
    set_in(3'd4, 4'b1111, 1'b0, 2'b11);
    repeat (2) @(posedge clk);
    #1 check_pop("reset", 4'b0000);
    check_out("reset", 2'b00, NONE, NONE);
    @(negedge clk);
    set_in(3'd0, 4'b0000, 1'b0, 2'b11);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      step($sformatf("vec%0d", k), tbl[k].sz, tbl[k].rdy, tbl[k].fl, tbl[k].rd,
           tbl[k].pop, tbl[k].ev, tbl[k].d0, tbl[k].d1);
    end

    // Starvation: seven younger issues are allowed, the eighth is blocked.
    for (int k = 0; k < 7; k++) begin
      step($sformatf("starve%0d", k), 3'd2, 4'b0010, 1'b0, 2'b11, 4'b0010, 2'b01, 1, 1);
    end
    step("starve_block", 3'd2, 4'b0010, 1'b0, 2'b11, 4'b0000, 2'b00, 1, 1);
    step("starve_old",   3'd2, 4'b0011, 1'b0, 2'b11, 4'b0001, 2'b01, 0, 1);
    step("starve_clr",   3'd2, 4'b0011, 1'b0, 2'b11, 4'b0011, 2'b11, 0, 1);

    // Flush clears the starvation counter.
    for (int k = 0; k < 7; k++) begin
      step($sformatf("fl_starve%0d", k), 3'd2, 4'b0010, 1'b0, 2'b11, 4'b0010, 2'b01, 1, 1);
    end
    step("fl_flush", 3'd2, 4'b0010, 1'b1, 2'b11, 4'b0011, 2'b00, 1, 1);
    step("fl_after", 3'd2, 4'b0010, 1'b0, 2'b11, 4'b0010, 2'b01, 1, 1);

    // Reset mid-issue drops held entries at once and suppresses pop.
    step("pre_rst", 3'd4, 4'b1111, 1'b0, 2'b11, 4'b0011, 2'b11, 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1 check_pop("rst_mid", 4'b0000);
    check_out("rst_mid", 2'b00, NONE, NONE);
    @(posedge clk);
    #1 check_out("rst_hold", 2'b00, NONE, NONE);
    @(negedge clk);
    rst = 1'b0;
    #1 check_pop("rst_rel", 4'b0011);
    @(posedge clk);
    #1 check_out("rst_rel", 2'b11, 0, 1);

    // Reset clears the starvation counter.
    for (int k = 0; k < 7; k++) begin
      step($sformatf("rs_starve%0d", k), 3'd2, 4'b0010, 1'b0, 2'b11, 4'b0010, 2'b01, 1, 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check_pop("rs_after", 4'b0010);
    @(posedge clk);
    #1 check_out("rs_after", 2'b01, 1, NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
